serial_to_parallel_register: RTL and testbench

//  Receive end of the serial link driven by linear_shift_register: captures a serial,
//  LSB-first bit stream and reassembles it into a WIDTH-bit parallel word.
//  A start strobe frames each word. out_valid pulses once per completed word.

---
 rtl/serial_to_parallel_register_pkg.sv | 14 +
 rtl/serial_to_parallel_register_if.sv | 24 ++
 rtl/serial_to_parallel_register_bit_counter.sv | 25 ++
 rtl/serial_to_parallel_register.sv | 105 ++++++++++
 tb/tb_serial_to_parallel_register.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/serial_to_parallel_register_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM state encodings and default sizing.
// The states are reused by the transmitter bench.
package serial_to_parallel_register_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } sipo_state_e;

  localparam int SIPO_WIDTH_DEF = 32;
  localparam int SIPO_CNT_W_DEF = 6;

endpackage

// File: rtl/serial_to_parallel_register_if.sv
// Serial-in / word-out bundle between a serial source and the receiver.
// The master drives the line and consumes words; the slave is the receiver.
interface serial_to_parallel_register_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             inp;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             parity_err;

  modport master (
    output start, inp,
    input  out, out_valid, busy, parity_err
  );

  modport slave (
    input  start, inp,
    output out, out_valid, busy, parity_err
  );

endinterface

// File: rtl/serial_to_parallel_register_bit_counter.sv
// Bit position counter for the receiver: synchronous clear, count enable,
// terminal-count flag raised while the count equals WIDTH-1.
module serial_to_parallel_register_bit_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_to_parallel_register.sv
// LSB-first serial receiver: a start strobe frames each WIDTH-bit word, out_valid pulses per word.
// Optional trailing even-parity bit check enabled by defining SIPO_PARITY_EN.
module serial_to_parallel_register
  import serial_to_parallel_register_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF,
  parameter int CNT_W = SIPO_CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  serial_to_parallel_register_if.slave   bus
);

  sipo_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt_word;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             last_bit;

  assign nxt_word = {bus.inp, shreg[WIDTH-1:1]};
  assign last_bit = (state == S_SHIFT) && cnt_tc;
  assign cnt_clr  = reset || last_bit;
  assign cnt_en   = ((state == S_IDLE) && bus.start) || (state == S_SHIFT);

  serial_to_parallel_register_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk (clk),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

`ifdef SIPO_PARITY_EN
  logic parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg  <= nxt_word;
            state  <= S_SHIFT;
            busy_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          // start is deliberately ignored here; a word cannot be restarted
          shreg <= nxt_word;
          if (cnt_tc) begin
`ifdef SIPO_PARITY_EN
            state <= S_PARITY;
`else
            out_q       <= nxt_word;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
            busy_q      <= 1'b0;
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        S_PARITY: begin
          // inp carries the even-parity bit; word plus parity must XOR to zero
          out_q        <= shreg;
          out_valid_q  <= 1'b1;
          parity_err_q <= (^shreg) ^ bus.inp;
          state        <= S_IDLE;
          busy_q       <= 1'b0;
        end
`endif
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_register.sv
// Bench for serial_to_parallel_register: directed and random words against a bit-position
// reference model. Parity cases run when SIPO_PARITY_EN is defined.
module tb_serial_to_parallel_register;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_to_parallel_register_if #(.WIDTH(W)) bus ();

  serial_to_parallel_register #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: collects bits by position into a word
  bit          m_active  = 1'b0;
  bit          m_parwait = 1'b0;
  int          m_pos     = 0;
  logic [W-1:0] m_acc    = '0;
  logic [W-1:0] m_out    = '0;
  logic        m_vld     = 1'b0;
  logic        m_perr    = 1'b0;

  int cyc       = 0;
  int vld_count = 0;
  int last_vld  = -1;
  int prev_vld  = -1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic s, input logic i, input logic r);
    if (r) begin
      m_active = 1'b0; m_parwait = 1'b0; m_pos = 0;
      m_acc = '0; m_out = '0; m_vld = 1'b0; m_perr = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (m_parwait) begin
        m_parwait = 1'b0;
        m_out     = m_acc;
        m_vld     = 1'b1;
        m_perr    = (^m_acc) ^ i;
      end else if (!m_active) begin
        if (s) begin
          m_acc[0] = i;
          m_pos    = 1;
          m_active = 1'b1;
        end
      end else begin
        m_acc[m_pos] = i;
        m_pos++;
        if (m_pos == W) begin
          m_active = 1'b0;
`ifdef SIPO_PARITY_EN
          m_parwait = 1'b1;
`else
          m_out = m_acc;
          m_vld = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic i, input logic r);
    bus.start = s;
    bus.inp   = i;
    reset     = r;
    model(s, i, r);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid === 1'b1) begin
      vld_count++;
      prev_vld = last_vld;
      last_vld = cyc;
    end
    chk("out", bus.out, m_out);
    chk("out_valid", W'(bus.out_valid), W'(m_vld));
    chk("busy", W'(bus.busy), W'(m_active | m_parwait));
    chk("parity_err", W'(bus.parity_err), W'(m_perr));
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic par,
                           input int restart_at, input int reset_at);
    for (int b = 0; b < W; b++) begin
      step((b == 0) || (b == restart_at), w[b], b == reset_at);
      if (b == reset_at) return;
    end
`ifdef SIPO_PARITY_EN
    step(1'b0, par, 1'b0);
`endif
  endtask

  int lat;
  int vc_save;
  logic [W-1:0] out_save;
  logic [W-1:0] rw;

  initial begin
    bus.start = 1'b0;
    bus.inp   = 1'b0;
    reset     = 1'b1;
`ifdef SIPO_PARITY_EN
    lat = W + 1;
`else
    lat = W;
`endif
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_out", bus.out, '0);
    chk("rst_busy", W'(bus.busy), '0);

    // loopback word 456 then 123 with zero gap
    vc_save = vld_count;
    send_word(32'd456, ^32'd456, -1, -1);
    chk("w456", bus.out, 32'd456);
    chk("w456_pulses", W'(vld_count - vc_save), W'(1));
    send_word(32'd123, ^32'd123, -1, -1);
    chk("w123", bus.out, 32'd123);
    chk("b2b_spacing", W'(last_vld - prev_vld), W'(lat));
    step(1'b0, 1'b0, 1'b0);
    chk("single_pulse", W'(bus.out_valid), '0);

    // start re-asserted mid-word is ignored
    send_word(32'hA5A5_F00F, ^32'hA5A5_F00F, 10, -1);
    chk("restart_ignored", bus.out, 32'hA5A5_F00F);

    // reset in the middle of a word discards it
    vc_save = vld_count;
    send_word(32'hFFFF_FFFF, 1'b0, -1, 17);
    chk("midrst_busy", W'(bus.busy), '0);
    chk("midrst_out", bus.out, '0);
    step(1'b0, 1'b1, 1'b0);
    chk("midrst_novalid", W'(vld_count - vc_save), '0);
    send_word(32'h0000_0001, 1'b1, -1, -1);
    chk("after_rst", bus.out, 32'h0000_0001);

    // idle line with random data and no start
    out_save = bus.out;
    vc_save  = vld_count;
    for (int k = 0; k < 50; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("idle_out", bus.out, out_save);
    chk("idle_pulses", W'(vld_count - vc_save), '0);
    chk("idle_busy", W'(bus.busy), '0);

    // random words with random gaps and stray start strobes
    for (int n = 0; n < 20; n++) begin
      rw = $urandom;
      send_word(rw, 1'($urandom_range(0, 1)), int'($urandom_range(1, W + 8)), -1);
      chk("rand_word", bus.out, rw);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef SIPO_PARITY_EN
    send_word(32'h3, 1'b0, -1, -1);
    chk("par_ok", W'(bus.parity_err), '0);
    step(1'b0, 1'b0, 1'b0);
    prev_vld = cyc;
    send_word(32'h3, 1'b1, -1, -1);
    chk("par_bad", W'(bus.parity_err), W'(1));
    chk("par_latency", W'(last_vld - prev_vld), W'(W + 1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
